// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the detector bench.
package seq_pkg;
  localparam int SEQ_PAT_W = 6;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 6'b110101;

  // One-hot state encoding.
  localparam int ST_IDLE_B = 0;
  localparam int ST_SEND_B = 1;
  localparam int ST_GAP_B  = 2;
  localparam int ST_DONE_B = 3;

  typedef enum logic [3:0] {
    ST_IDLE = 4'(1 << ST_IDLE_B),
    ST_SEND = 4'(1 << ST_SEND_B),
    ST_GAP  = 4'(1 << ST_GAP_B),
    ST_DONE = 4'(1 << ST_DONE_B)
  } seq_state_e;
endpackage

// File: rtl/seq_pattern_tx_if.sv
// Control/serial bundle of seq_pattern_tx. ABORT_EN adds the abort/aborted pair.
interface seq_pattern_tx_if #(
  parameter int GAP_W = 4,
  parameter int RPT_W = 4
);
  logic             start;
  logic [GAP_W-1:0] gap_len;
  logic [RPT_W-1:0] repeat_cnt;
  logic             x_out;
  logic             valid;
  logic             busy;
  logic             done;
`ifdef ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (output start, gap_len, repeat_cnt, abort,
                  input  x_out, valid, busy, done, aborted);
  modport slave  (input  start, gap_len, repeat_cnt, abort,
                  output x_out, valid, busy, done, aborted);
`else
  modport master (output start, gap_len, repeat_cnt,
                  input  x_out, valid, busy, done);
  modport slave  (input  start, gap_len, repeat_cnt,
                  output x_out, valid, busy, done);
`endif
endinterface

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero flag; load wins over decrement, holds at zero.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: N frames of PATTERN (MSB first) separated by zero gaps.
// Optional abort input / aborted pulse when ABORT_EN is defined.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int                PAT_W   = SEQ_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = SEQ_PATTERN,
  parameter int                GAP_W   = 4,
  parameter int                RPT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_tx_if.slave   bus
);
  localparam int BW = $clog2(PAT_W);

  seq_state_e       state_q, state_d;
  logic [GAP_W-1:0] gap_q;
  logic             accept;

  logic             bit_load, bit_dec, bit_zero;
  logic [BW-1:0]    bit_cnt;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_cnt;
  logic             frm_load, frm_dec, frm_zero;
  logic [RPT_W-1:0] frm_cnt, frm_init;

  // Frame counter holds frames remaining after the current one, so zero marks the last.
  assign frm_init = (bus.repeat_cnt == '0) ? '0 : bus.repeat_cnt - 1'b1;
  assign accept   = (state_q == ST_IDLE) && bus.start;

  seq_down_counter #(.W(BW)) u_bit (
    .clk(clk), .reset(reset), .load_i(bit_load), .dec_i(bit_dec),
    .val_i(BW'(PAT_W-1)), .cnt_o(bit_cnt), .zero_o(bit_zero));

  seq_down_counter #(.W(GAP_W)) u_gap (
    .clk(clk), .reset(reset), .load_i(gap_load), .dec_i(gap_dec),
    .val_i(gap_q - 1'b1), .cnt_o(gap_cnt), .zero_o(gap_zero));

  seq_down_counter #(.W(RPT_W)) u_frm (
    .clk(clk), .reset(reset), .load_i(frm_load), .dec_i(frm_dec),
    .val_i(frm_init), .cnt_o(frm_cnt), .zero_o(frm_zero));

  logic unused_cnt;
  assign unused_cnt = ^{gap_cnt, frm_cnt};

`ifdef ABORT_EN
  logic abort_hit, aborted_q;
  assign abort_hit = bus.abort && (state_q == ST_SEND || state_q == ST_GAP);
`endif

  always_comb begin
    state_d  = state_q;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    frm_load = 1'b0;
    frm_dec  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d  = ST_SEND;
        bit_load = 1'b1;
        frm_load = 1'b1;
      end
      ST_SEND: if (!bit_zero) begin
        bit_dec = 1'b1;
      end else if (!frm_zero) begin
        frm_dec = 1'b1;
        if (gap_q != '0) begin
          gap_load = 1'b1;
          state_d  = ST_GAP;
        end else begin
          bit_load = 1'b1;
        end
      end else begin
        state_d = ST_DONE;
      end
      ST_GAP: if (gap_zero) begin
        bit_load = 1'b1;
        state_d  = ST_SEND;
      end else begin
        gap_dec = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef ABORT_EN
    if (abort_hit) state_d = ST_IDLE;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) gap_q <= bus.gap_len;
    end
  end

`ifdef ABORT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) aborted_q <= 1'b0;
    else       aborted_q <= abort_hit;
  end
  assign bus.aborted = aborted_q;
`endif

  assign bus.valid = (state_q == ST_SEND);
  assign bus.x_out = (state_q == ST_SEND) && PATTERN[bit_cnt];
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: vector table of jobs plus hand-written corner sequences.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_pattern_tx_if #(.GAP_W(4), .RPT_W(4)) bus ();
  seq_pattern_tx #(.PAT_W(6), .PATTERN(6'b110101), .GAP_W(4), .RPT_W(4)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    int rpt; int gap; int nbits; int busy; int gapcyc; int det;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one job and measures it, with a non-overlapping 110101 detector on x_out.
  task automatic run_job(input vec_t v, input string tag);
    logic [5:0] pat;
    logic [5:0] sr;
    int nb, bz, gc, dn, sb, dc, since;
    bit fin;
    pat = 6'b110101; sr = '0;
    nb = 0; bz = 0; gc = 0; dn = 0; sb = 0; dc = 0; since = 6; fin = 1'b0;
    bus.start = 1'b1; bus.repeat_cnt = 4'(v.rpt); bus.gap_len = 4'(v.gap);
    tick();
    bus.start = 1'b0; bus.repeat_cnt = 4'd7; bus.gap_len = 4'd9;
    chk({tag, " first_bit"}, int'({bus.valid, bus.x_out}), 3);
    for (int c = 0; c < 400 && !fin; c++) begin
      if (bus.busy) bz++;
      if (bus.valid) begin
        if (bus.x_out !== pat[5 - (nb % 6)]) sb++;
        nb++;
      end else if (bus.x_out !== 1'b0) sb++;
      if (bus.busy && !bus.valid && !bus.done) gc++;
      sr = {sr[4:0], bus.x_out};
      since++;
      if (sr == 6'b110101 && since >= 6) begin dc++; since = 0; end
      if (bus.done) begin dn++; fin = 1'b1; end
      tick();
    end
    chk({tag, " finished"}, int'(fin), 1);
    chk({tag, " nbits"}, nb, v.nbits);
    chk({tag, " stream_err"}, sb, 0);
    chk({tag, " busy_cyc"}, bz, v.busy);
    chk({tag, " gap_cyc"}, gc, v.gapcyc);
    chk({tag, " det_pulses"}, dc, v.det);
    chk({tag, " idle_after"}, int'(bus.busy), 0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.done || bus.valid) dn++;
      tick();
    end
    chk({tag, " quiet_after"}, dn, 0);
  endtask

  initial begin
    int nv, nd, k;
    logic [10:1] busy_v;
    logic [10:1] valid_v;

    tbl[0] = '{1, 0, 6, 7, 0, 1};
    tbl[1] = '{3, 2, 18, 23, 4, 3};
    tbl[2] = '{0, 0, 6, 7, 0, 1};
    tbl[3] = '{2, 0, 12, 13, 0, 2};
    tbl[4] = '{2, 15, 12, 28, 15, 2};
    tbl[5] = '{15, 1, 90, 105, 14, 15};

    reset = 1'b1;
    bus.start = 1'b0; bus.gap_len = '0; bus.repeat_cnt = '0;
`ifdef ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) tick();
    chk("rst x_out", int'(bus.x_out), 0);
    chk("rst valid", int'(bus.valid), 0);
    chk("rst busy",  int'(bus.busy),  0);
    chk("rst done",  int'(bus.done),  0);
`ifdef ABORT_EN
    chk("rst aborted", int'(bus.aborted), 0);
`endif
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_job(tbl[i], $sformatf("vec%0d", i));

    // start pulsed during SEND is ignored
    bus.start = 1'b1; bus.repeat_cnt = 4'd1; bus.gap_len = 4'd0;
    tick();
    nv = 0; nd = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.valid) nv++;
      if (bus.done) nd++;
      bus.start = (c == 3);
      tick();
    end
    chk("ign_start valid", nv, 6);
    chk("ign_start done", nd, 1);

    // start held high: one idle cycle between jobs
    bus.start = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      busy_v[c]  = bus.busy;
      valid_v[c] = bus.valid & bus.x_out;
      tick();
    end
    bus.start = 1'b0;
    chk("held busy_pattern", int'(busy_v), 10'b1101111111);
    chk("held restart_bit", int'(valid_v[9]), 1);
    k = 0;
    while (!bus.done && k < 30) begin tick(); k++; end
    chk("held second_done", int'(bus.done), 1);
    repeat (2) tick();

    // async reset at bit 3 of frame 2
    bus.start = 1'b1; bus.repeat_cnt = 4'd3; bus.gap_len = 4'd2;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    chk("rst_mid pre_valid", int'({bus.busy, bus.valid}), 3);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid outputs", int'({bus.busy, bus.valid, bus.x_out}), 0);
    tick();
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done || bus.busy) nd++;
      tick();
    end
    chk("rst_mid no_done", nd, 0);
    run_job(tbl[0], "post_rst");

`ifdef ABORT_EN
    // abort during GAP of a 3-frame job
    bus.start = 1'b1; bus.repeat_cnt = 4'd3; bus.gap_len = 4'd3;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    chk("abort in_gap", int'({bus.busy, bus.valid}), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort pulse", int'({bus.aborted, bus.busy, bus.done}), 4);
    tick();
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.valid || bus.done || bus.aborted || bus.busy) nv++;
      tick();
    end
    chk("abort quiet", nv, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the companion of the team's non-overlapping Moore sequence detector.
- Emits a fixed bit pattern (default 110101), MSB first, one bit per clock, on a serial line that feeds the detector's x input.
- A programmable number of frames is sent, separated by programmable zero-gaps.
- Used as the stimulus source in loopback and on-chip self-test.

Parameters:
- PAT_W, 6, pattern length in bits (≥2).
- PATTERN, 6'b110101, pattern transmitted, bit PAT_W-1 first.
- GAP_W, 4, width of the inter-frame gap length field.
- RPT_W, 4, width of the frame repeat count field.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- gap_len  in  GAP_W  zero cycles inserted between frames; latched on accepted start
- repeat_cnt  in  RPT_W  number of frames; 0 treated as 1; latched on accepted start
- x_out  out  1  serial data to detector
- valid  out  1  high while x_out carries a pattern bit
- busy  out  1  high from the cycle after accepted start through DONE
- done  out  1  one-cycle pulse after the last frame's last bit

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high. On reset: state=IDLE; x_out=0, valid=0, busy=0, done=0; all counters cleared. Reset mid-frame aborts immediately; no done pulse.
- All outputs are registered and decoded from the registered state/counters; no combinational input-to-output path.
- States (one-hot): IDLE, SEND, GAP, DONE.
- IDLE:
  - start=1 latches gap_len and repeat_cnt (0→1), loads bit_idx=PAT_W-1, and goes to SEND.
  - Accept-to-first-bit latency is 1 cycle.
- SEND:
  - x_out=PATTERN[bit_idx], valid=1, busy=1.
  - bit_idx decrements each cycle.
  - At bit_idx=0:
    - If frames remain and gap≠0 → GAP.
    - If frames remain and gap=0 → reload bit_idx and stay in SEND; frames are back-to-back with no bubble.
    - Else → DONE.
- GAP: x_out=0, valid=0, busy=1 for exactly gap_len cycles, then reload bit_idx and go to SEND.
- DONE: done=1, busy=1, x_out=0, valid=0 for one cycle, then → IDLE.
- start while not in IDLE is ignored; no queuing. start high in the DONE cycle is also ignored. start held high in IDLE restarts on the cycle after DONE→IDLE, i.e. 1 idle cycle between jobs.
- Frame counter decrements on each frame's last bit; remaining-frame test uses the pre-decrement value.
- Total busy cycles = N·PAT_W + (N-1)·gap_len + 1, where N = effective repeat count.
- Changes to gap_len/repeat_cnt inputs mid-job have no effect.
- Counter widths: bit_idx uses $clog2(PAT_W); counters never wrap, because the loads bound them.

Optional Feature:
- Macro ABORT_EN.
- Defined:
  - Adds input port abort (1 bit) and output port aborted (1 bit, one-cycle pulse).
  - abort=1 in SEND or GAP → next cycle IDLE, x_out=0, valid=0, busy=0, aborted=1 for one cycle, done not pulsed.
  - abort is ignored in IDLE and DONE.
  - abort takes priority over the frame-end transition.
- Not defined: neither port exists and behaviour is as above.

Decomposition:
- Shared package seq_pkg:
  - one-hot state localparams (IDLE, SEND, GAP, DONE);
  - default pattern constant 6'b110101 and its width, shared with the detector bench.
- One natural sub-module, seq_down_counter: loadable down-counter with a zero flag, parameterized width. Instantiated for bit_idx, gap count and frame count.

Test Plan:
- Reset then start=1 for 1 cycle with repeat_cnt=1, gap_len=0 → x_out=1,1,0,1,0,1 with valid=1 on cycles 1-6 after accept; done on cycle 7; busy high for cycles 1-7; detector loopback gives exactly one y pulse.
- repeat_cnt=3, gap_len=2 → three 6-bit frames with 2 zero cycles between them; busy length 3·6+2·2+1=23; detector y pulses 3 times.
- repeat_cnt=0, gap_len=0 → behaves as 1 frame. repeat_cnt=2, gap_len=0 → 12 contiguous valid bits 110101110101; 2 detector pulses.
- start pulsed during SEND of a 1-frame job → ignored; exactly one done. start held high continuously → new job begins on the cycle after done, with 1 idle cycle between jobs.
- Reset asserted asynchronously at bit 3 of frame 2 → x_out, valid and busy are 0 immediately; no done pulse; a new start afterwards yields a normal frame.
- With ABORT_EN defined: abort during GAP of a 3-frame job → next cycle IDLE with aborted=1 and busy=0; no done pulse; no further valid bits.
